// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: M/A/Q/Q_m1 registers driven by an external
// controller, plus a product register latched on the rising edge of done_sig.
module booth_datapath #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 M_sig,
    input  logic [1:0]           Q_sig,
    input  logic [1:0]           A_sig,
    input  logic                 adder_sig,
    input  logic                 done_sig,
    output logic [1:0]           Q_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_RESET = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_HOLD  = 2'b11;

    logic [WIDTH:0]       m_r;
    logic [WIDTH:0]       a_r;
    logic [WIDTH-1:0]     q_r;
    logic                 q_m1_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 product_valid_r;
    logic                 done_d_r;

    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       a_next_s;
    logic [WIDTH-1:0]     q_next_s;
    logic                 q_m1_next_s;
    logic                 completion_s;

    // A+M or A-M, wrapping at WIDTH+1 bits so -2^(WIDTH-1) can be negated.
    function automatic logic [WIDTH:0] add_sub(input logic [WIDTH:0] a,
                                               input logic [WIDTH:0] m,
                                               input logic           sub);
        if (sub) begin
            add_sub = a - m;
        end else begin
            add_sub = a + m;
        end
    endfunction

    assign sum_s        = add_sub(a_r, m_r, adder_sig);
    assign completion_s = done_sig & ~done_d_r;
    assign Q_in         = {q_r[0], q_m1_r};
    assign product       = product_r;
    assign product_valid = product_valid_r;

    // Next value of A from its operation code.
    always_comb begin
        a_next_s = a_r;
        case (A_sig)
            OP_LOAD:  a_next_s = sum_s;
            OP_RESET: a_next_s = '0;
            OP_SHIFT: a_next_s = {a_r[WIDTH], a_r[WIDTH:1]};
            OP_HOLD:  a_next_s = a_r;
            default:  a_next_s = a_r;
        endcase
    end

    // Next value of Q/Q_m1; shifting pulls in the pre-edge A[0].
    always_comb begin
        q_next_s    = q_r;
        q_m1_next_s = q_m1_r;
        case (Q_sig)
            OP_LOAD: begin
                q_next_s    = multiplier;
                q_m1_next_s = 1'b0;
            end
            OP_RESET: begin
                q_next_s    = '0;
                q_m1_next_s = 1'b0;
            end
            OP_SHIFT: begin
                q_next_s    = {a_r[0], q_r[WIDTH-1:1]};
                q_m1_next_s = q_r[0];
            end
            OP_HOLD: begin
                q_next_s    = q_r;
                q_m1_next_s = q_m1_r;
            end
            default: begin
                q_next_s    = q_r;
                q_m1_next_s = q_m1_r;
            end
        endcase
    end

    // Operand and accumulator registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_r    <= '0;
            a_r    <= '0;
            q_r    <= '0;
            q_m1_r <= 1'b0;
        end else begin
            if (M_sig) begin
                m_r <= {multiplicand[WIDTH-1], multiplicand};
            end else begin
                m_r <= m_r;
            end
            a_r    <= a_next_s;
            q_r    <= q_next_s;
            q_m1_r <= q_m1_next_s;
        end
    end

    // Result latch: completion beats a simultaneous new-operand load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            product_r       <= '0;
            product_valid_r <= 1'b0;
            done_d_r        <= 1'b0;
        end else begin
            done_d_r <= done_sig;
            if (completion_s) begin
                product_r       <= {a_r[WIDTH-1:0], q_r};
                product_valid_r <= 1'b1;
            end else if (M_sig) begin
                product_r       <= product_r;
                product_valid_r <= 1'b0;
            end else begin
                product_r       <= product_r;
                product_valid_r <= product_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: directed vectors, randomized operands
// against an integer-multiply reference, and hand-written control sequences.
module tb_booth_datapath;

    localparam int W = 4;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_RESET = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_HOLD  = 2'b11;

    logic             clock;
    logic             reset_n;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic             M_sig;
    logic [1:0]       Q_sig;
    logic [1:0]       A_sig;
    logic             adder_sig;
    logic             done_sig;
    logic [1:0]       Q_in;
    logic [2*W-1:0]   product;
    logic             product_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    booth_datapath #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .M_sig         (M_sig),
        .Q_sig         (Q_sig),
        .A_sig         (A_sig),
        .adder_sig     (adder_sig),
        .done_sig      (done_sig),
        .Q_in          (Q_in),
        .product       (product),
        .product_valid (product_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ctrl();
        M_sig     = 1'b0;
        Q_sig     = OP_HOLD;
        A_sig     = OP_HOLD;
        adder_sig = 1'b0;
        done_sig  = 1'b0;
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        int mi;
        int qi;
        int p;
        mi = $signed(m);
        qi = $signed(q);
        p  = mi * qi;
        return p[2*W-1:0];
    endfunction

    // Drives a complete Booth sequence; the recoding pairs come from the bench's own copy of q.
    task automatic run_booth(input logic [W-1:0] m, input logic [W-1:0] q,
                             input logic [2*W-1:0] exp, input string name);
        logic prev;
        logic [1:0] pair;
        idle_ctrl();
        multiplicand = m;
        multiplier   = q;
        M_sig = 1'b1;
        Q_sig = OP_LOAD;
        A_sig = OP_RESET;
        tick();
        chk({name, "_valid_cleared"}, {31'd0, product_valid}, 32'd0);
        idle_ctrl();
        prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            pair = {q[i], prev};
            chk({name, "_Q_in"}, {30'd0, Q_in}, {30'd0, pair});
            if (pair == 2'b01 || pair == 2'b10) begin
                A_sig     = OP_LOAD;
                adder_sig = (pair == 2'b10);
                tick();
                idle_ctrl();
            end
            A_sig = OP_SHIFT;
            Q_sig = OP_SHIFT;
            tick();
            idle_ctrl();
            prev = q[i];
        end
        done_sig = 1'b1;
        tick();
        idle_ctrl();
        chk({name, "_product"}, {24'd0, product}, {24'd0, exp});
        chk({name, "_valid"}, {31'd0, product_valid}, 32'd1);
        tick();
    endtask

    initial begin
        logic [W-1:0] rm;
        logic [W-1:0] rq;

        vecs[0] = '{4'h3, 4'hE, 8'hFA};
        vecs[1] = '{4'h8, 4'h8, 8'h40};
        vecs[2] = '{4'h7, 4'h7, 8'h31};
        vecs[3] = '{4'h0, 4'hB, 8'h00};
        vecs[4] = '{4'hF, 4'hF, 8'h01};
        vecs[5] = '{4'h7, 4'h8, 8'hC8};
        vecs[6] = '{4'h1, 4'h8, 8'hF8};

        reset_n      = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        idle_ctrl();
        tick();
        chk("reset_product", {24'd0, product}, 32'd0);
        chk("reset_valid", {31'd0, product_valid}, 32'd0);
        chk("reset_Q_in", {30'd0, Q_in}, 32'd0);
        #2;
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            run_booth(vecs[v].m, vecs[v].q, vecs[v].exp, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 40; r++) begin
            rm = W'($urandom_range(0, (1 << W) - 1));
            rq = W'($urandom_range(0, (1 << W) - 1));
            run_booth(rm, rq, ref_mul(rm, rq), "rand");
        end

        // Combined shift: A=00101, Q=0011, Q_m1=0 -> A=00010, Q=1001, Q_m1=1.
        idle_ctrl();
        multiplicand = 4'd5;
        multiplier   = 4'b0011;
        M_sig = 1'b1;
        Q_sig = OP_LOAD;
        A_sig = OP_RESET;
        tick();
        idle_ctrl();
        A_sig = OP_LOAD;
        tick();
        idle_ctrl();
        A_sig = OP_SHIFT;
        Q_sig = OP_SHIFT;
        tick();
        idle_ctrl();
        chk("shift_Q_in", {30'd0, Q_in}, 32'h3);
        done_sig = 1'b1;
        tick();
        idle_ctrl();
        chk("shift_AQ", {24'd0, product}, 32'h29);
        tick();

        // Subtract into A while Q shifts in the old A[0].
        multiplicand = 4'd3;
        multiplier   = 4'b0110;
        M_sig = 1'b1;
        Q_sig = OP_LOAD;
        A_sig = OP_RESET;
        tick();
        idle_ctrl();
        A_sig     = OP_LOAD;
        adder_sig = 1'b1;
        Q_sig     = OP_SHIFT;
        tick();
        idle_ctrl();
        chk("sub_Q_in", {30'd0, Q_in}, 32'h2);

        // done held for three edges: only the first loads.
        done_sig = 1'b1;
        tick();
        chk("sub_AQ", {24'd0, product}, 32'hD3);
        chk("held_valid", {31'd0, product_valid}, 32'd1);
        A_sig = OP_RESET;
        tick();
        A_sig = OP_HOLD;
        tick();
        chk("held_no_reload", {24'd0, product}, 32'hD3);
        idle_ctrl();
        M_sig = 1'b1;
        tick();
        idle_ctrl();
        chk("mload_valid_clear", {31'd0, product_valid}, 32'd0);
        chk("mload_product_hold", {24'd0, product}, 32'hD3);

        // Completion and M load on the same edge: completion wins (A=0, Q=0011).
        done_sig = 1'b1;
        M_sig    = 1'b1;
        tick();
        idle_ctrl();
        chk("tie_valid", {31'd0, product_valid}, 32'd1);
        chk("tie_product", {24'd0, product}, 32'h03);
        tick();

        // Asynchronous reset mid-sequence, with controls active during reset.
        multiplicand = 4'd6;
        multiplier   = 4'd5;
        M_sig = 1'b1;
        Q_sig = OP_LOAD;
        A_sig = OP_RESET;
        tick();
        idle_ctrl();
        A_sig = OP_LOAD;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_product", {24'd0, product}, 32'd0);
        chk("async_valid", {31'd0, product_valid}, 32'd0);
        chk("async_Q_in", {30'd0, Q_in}, 32'd0);
        done_sig = 1'b1;
        M_sig    = 1'b1;
        Q_sig    = OP_LOAD;
        tick();
        chk("rst_ignore_product", {24'd0, product}, 32'd0);
        chk("rst_ignore_Q_in", {30'd0, Q_in}, 32'd0);
        idle_ctrl();
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", {31'd0, product_valid}, 32'd0);
        run_booth(4'd6, 4'hB, 8'hE2, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_datapath.md
BOOTH_DATAPATH -- requirements
Module: booth_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clock, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port multiplicand, input, WIDTH bits, signed operand M.
REQ-005 The block SHALL have port multiplier, input, WIDTH bits, signed operand Q.
REQ-006 The block SHALL have port M_sig, input, 1 bit; 1 = load M register, 0 = hold.
REQ-007 The block SHALL have port Q_sig, input, 2 bits, Q register op: 00 Load, 01 Reset, 10 Shift, 11 Hold.
REQ-008 The block SHALL have port A_sig, input, 2 bits, A register op, same encoding as Q_sig.
REQ-009 The block SHALL have port adder_sig, input, 1 bit; 0 = A+M, 1 = A-M.
REQ-010 The block SHALL have port done_sig, input, 1 bit, controller completion flag.
REQ-011 The block SHALL have port Q_in, output, 2 bits, {Q[0], Q_m1}, returned to the controller.
REQ-012 The block SHALL have port product, output, 2*WIDTH bits, latched signed result.
REQ-013 The block SHALL have port product_valid, output, 1 bit, high while product holds a completed result.

Function
REQ-014 State SHALL be: M (WIDTH+1 bits, sign-extended), A (WIDTH+1 bits), Q (WIDTH bits), Q_m1 (1 bit), product register, product_valid, done_d (previous done_sig).
REQ-015 All control inputs SHALL be sampled at the rising edge of clock; Q_in SHALL be a direct combinational function of Q and Q_m1.
REQ-016 M_sig=1 SHALL load M with sign-extended multiplicand; M_sig=0 SHALL hold M.
REQ-017 Adder result SHALL be A+M (adder_sig=0) or A-M (adder_sig=1), computed on pre-edge A and M, WIDTH+1 bits, modulo 2^(WIDTH+1).
REQ-018 A_sig Load SHALL write the adder result into A; A_sig Reset SHALL clear A; A_sig Hold SHALL keep A.
REQ-019 A_sig Shift SHALL arithmetic-shift A right one bit (MSB replicated).
REQ-020 Q_sig Load SHALL load multiplier into Q and clear Q_m1; Q_sig Reset SHALL clear Q and Q_m1; Q_sig Hold SHALL keep both.
REQ-021 Q_sig Shift SHALL set Q <= {pre-edge A[0], Q[WIDTH-1:1]} and Q_m1 <= pre-edge Q[0].
REQ-022 A and Q operations SHALL be independent; any A_sig/Q_sig combination is legal and SHALL use pre-edge values only (e.g. A Load with Q Shift shifts in the old A[0]).
REQ-023 On a rising edge where done_sig=1 and done_d=0, product SHALL load {A[WIDTH-1:0], Q} and product_valid SHALL set to 1.
REQ-024 done_sig held high on later edges SHALL NOT reload product.
REQ-025 M_sig=1 SHALL clear product_valid on that edge; product value SHALL be held until the next completion.
REQ-026 If completion (REQ-023) and M_sig=1 occur on the same edge, completion SHALL win: product loads and product_valid=1.
REQ-027 For a standard Booth sequence (M/Q Load and A Reset, then WIDTH iterations of optional add/sub then combined A/Q Shift), product SHALL equal the exact signed product for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1).

Reset
REQ-028 reset_n=0 SHALL immediately, without a clock, clear M, A, Q, Q_m1, product, product_valid and done_d; Q_in and product read 0.
REQ-029 Reset asserted mid-multiplication SHALL abandon the operation; after release no product_valid SHALL assert until a new completion edge.
REQ-030 Control inputs SHALL be ignored while reset_n=0.

Verification
REQ-031 WIDTH=4, multiplicand=3, multiplier=-2 (4'hE), full Booth sequence -> product=8'hFA, product_valid=1.
REQ-032 WIDTH=4, -8 * -8 -> product=8'h40; 7 * 7 -> product=8'h31; 0 * -5 -> product=8'h00.
REQ-033 A=5'b00101, Q=4'b0011, Q_m1=0, A_sig=Q_sig=Shift -> A=5'b00010, Q=4'b1001, Q_m1=1, Q_in=2'b11.
REQ-034 A_sig=Load, adder_sig=1, A=0, M=3 -> A=5'b11101; same edge Q_sig=Shift shifts in old A[0]=0.
REQ-035 done_sig held high 3 cycles -> product loaded once; then M_sig=1 -> product_valid=0, product unchanged.
REQ-036 reset_n pulsed low between clock edges mid-sequence -> all outputs 0 immediately; next full sequence produces correct product.
